// File: rtl/next_pc_unit.sv
// Registered MIPS program-counter sequencer with exception redirect, stall and a
// circular return-address stack that is pushed on jal and popped on jr.
module next_pc_unit #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter logic [31:0]       EXC_VECTOR   = 32'h8000_0180,
    parameter int                RAS_DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instruction,
    input  logic              zero,
    input  logic              branch_sel,
    input  logic              jump_sel,
    input  logic              link_sel,
    input  logic              jr_sel,
    input  logic [ADDR_W-1:0] reg_target,
    input  logic              stall,
    input  logic              exception,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-1:0] epc,
    output logic [ADDR_W-1:0] ras_top,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_mispredict
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  top_ptr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] seq_target;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] jmp_target;
    logic [ADDR_W-1:0] reg_aligned;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] top_entry;
    logic              push;
    logic              pop;
    logic              advance;

    assign seq_target  = pc + ADDR_W'(4);
    assign br_target   = seq_target + ({{(ADDR_W-16){instruction[15]}}, instruction[15:0]} << 2);
    assign jmp_target  = {seq_target[ADDR_W-1:28], instruction[25:0], 2'b00};
    assign reg_aligned = {reg_target[ADDR_W-1:2], 2'b00};
    assign pc_plus4    = seq_target;

    // wr_ptr points at the next free slot; the newest entry sits one below it.
    assign top_ptr   = (wr_ptr == '0) ? PTR_LAST : wr_ptr - PTR_W'(1);
    assign top_entry = ras_mem[top_ptr];
    assign ras_empty = (count == '0);
    assign ras_full  = (count == CNT_FULL);
    assign ras_top   = ras_empty ? '0 : top_entry;
    assign advance   = rst_n && !exception && !stall;

    always_comb begin
        next_pc = seq_target;
        push    = 1'b0;
        pop     = 1'b0;
        if (jr_sel) begin
            next_pc = reg_aligned;
            pop     = 1'b1;
        end else if (jump_sel) begin
            next_pc = jmp_target;
            push    = link_sel;
        end else if (branch_sel && zero) begin
            next_pc = br_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc             <= RESET_VECTOR;
            epc            <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            ras_mispredict <= 1'b0;
        end else if (exception) begin
            pc             <= ADDR_W'(EXC_VECTOR);
            epc            <= pc;
            ras_mispredict <= 1'b0;
        end else if (!stall) begin
            pc             <= next_pc;
            ras_mispredict <= pop && (ras_empty || top_entry != reg_aligned);
            if (push) begin
                // A push into a full stack silently overwrites the oldest slot.
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
                if (!ras_full) count <= count + CNT_W'(1);
            end else if (pop && !ras_empty) begin
                wr_ptr <= top_ptr;
                count  <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (advance && push) ras_mem[wr_ptr] <= seq_target;
    end
endmodule

// File: tb/tb_next_pc_unit.sv
// Self-checking bench for next_pc_unit: directed scenarios with literal checks,
// then randomized traffic compared every cycle against a queue-based model.
module tb_next_pc_unit;
    localparam int DEPTH = 4;
    localparam logic [31:0] EXC = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instruction;
    logic        zero, branch_sel, jump_sel, link_sel, jr_sel, stall, exception;
    logic [31:0] reg_target;
    logic [31:0] pc, pc_plus4, epc, ras_top;
    logic        ras_empty, ras_full, ras_mispredict;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_pc, m_epc;
    logic        m_mis;
    logic [31:0] ras_q[$];

    next_pc_unit #(.ADDR_W(32), .RESET_VECTOR(32'h0), .EXC_VECTOR(EXC), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .zero(zero),
        .branch_sel(branch_sel), .jump_sel(jump_sel), .link_sel(link_sel), .jr_sel(jr_sel),
        .reg_target(reg_target), .stall(stall), .exception(exception),
        .pc(pc), .pc_plus4(pc_plus4), .epc(epc), .ras_top(ras_top),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_mispredict(ras_mispredict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural rules applied to the model state for one clock edge.
    task automatic model_edge();
        logic [31:0] s, r, top;
        if (!rst_n) begin
            m_pc = 32'h0; m_epc = 32'h0; m_mis = 1'b0; ras_q.delete();
        end else if (exception) begin
            m_epc = m_pc; m_pc = EXC; m_mis = 1'b0;
        end else if (!stall) begin
            s = m_pc + 32'd4;
            m_mis = 1'b0;
            if (jr_sel) begin
                r = {reg_target[31:2], 2'b00};
                if (ras_q.size() == 0) m_mis = 1'b1;
                else begin
                    top = ras_q.pop_back();
                    m_mis = (top != r);
                end
                m_pc = r;
            end else if (jump_sel) begin
                if (link_sel) begin
                    if (ras_q.size() == DEPTH) void'(ras_q.pop_front());
                    ras_q.push_back(s);
                end
                m_pc = {s[31:28], instruction[25:0], 2'b00};
            end else if (branch_sel && zero) begin
                m_pc = s + ({{16{instruction[15]}}, instruction[15:0]} << 2);
            end else begin
                m_pc = s;
            end
        end
    endtask

    task automatic check_all();
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("epc", epc, m_epc);
        chk("ras_top", ras_top, (ras_q.size() == 0) ? 32'h0 : ras_q[$]);
        chk("ras_empty", ras_empty, ras_q.size() == 0);
        chk("ras_full", ras_full, ras_q.size() == DEPTH);
        chk("ras_mispredict", ras_mispredict, m_mis);
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        rst_n = 1'b1; instruction = 32'h0; zero = 1'b0; branch_sel = 1'b0; jump_sel = 1'b0;
        link_sel = 1'b0; jr_sel = 1'b0; reg_target = 32'h0; stall = 1'b0; exception = 1'b0;
    endtask

    task automatic do_jump(input logic [25:0] idx, input logic link);
        idle(); jump_sel = 1'b1; link_sel = link; instruction = {6'h02, idx}; cycle();
    endtask

    task automatic do_jr(input logic [31:0] tgt);
        idle(); jr_sel = 1'b1; reg_target = tgt; cycle();
    endtask

    task automatic do_beq(input logic [15:0] off, input logic z);
        idle(); branch_sel = 1'b1; zero = z; instruction = {6'h04, 10'h0, off}; cycle();
    endtask

    initial begin
        idle();
        rst_n = 1'b0; exception = 1'b1; stall = 1'b1;
        cycle();
        chk("rst_pc", pc, 32'h0);
        chk("rst_empty", ras_empty, 1'b1);
        idle();
        cycle(); chk("idle_pc1", pc, 32'h4);
        cycle(); chk("idle_pc2", pc, 32'h8);
        cycle(); chk("idle_pc3", pc, 32'hC);
        chk("idle_epc", epc, 32'h0);

        do_jump(26'h40, 1'b0);      chk("j_0x100", pc, 32'h100);
        do_beq(16'hFFFF, 1'b1);     chk("beq_back", pc, 32'h100);
        do_beq(16'hFFFF, 1'b0);     chk("beq_not", pc, 32'h104);
        do_jump(26'h40, 1'b0);
        do_beq(16'h0003, 1'b1);     chk("beq_fwd", pc, 32'h110);

        do_jr(32'h4000_0010);       chk("jr_hi", pc, 32'h4000_0010);
        do_jump(26'h40, 1'b1);
        chk("jal_pc", pc, 32'h4000_0100);
        chk("jal_top", ras_top, 32'h4000_0014);
        do_jr(32'h4000_0014);
        chk("ret_pc", pc, 32'h4000_0014);
        chk("ret_empty", ras_empty, 1'b1);
        chk("ret_mis", ras_mispredict, 1'b0);

        idle(); rst_n = 1'b0; cycle();
        do_jump(26'h04, 1'b1); do_jump(26'h08, 1'b1); do_jump(26'h0C, 1'b1);
        do_jump(26'h10, 1'b1); do_jump(26'h40, 1'b1);
        chk("ras_full5", ras_full, 1'b1);
        chk("ras_top5", ras_top, 32'h44);
        do_jr(32'h44); chk("pop1_mis", ras_mispredict, 1'b0); chk("pop1_top", ras_top, 32'h34);
        do_jr(32'h34); chk("pop2_mis", ras_mispredict, 1'b0);
        do_jr(32'h24); chk("pop3_mis", ras_mispredict, 1'b0);
        do_jr(32'h14); chk("pop4_mis", ras_mispredict, 1'b0); chk("pop4_empty", ras_empty, 1'b1);
        do_jr(32'h300); chk("pop5_mis", ras_mispredict, 1'b1); chk("pop5_pc", pc, 32'h300);
        idle(); cycle(); chk("mis_pulse_end", ras_mispredict, 1'b0);

        do_jr(32'h203); chk("jr_align", pc, 32'h200);
        idle(); jump_sel = 1'b1; branch_sel = 1'b1; zero = 1'b1; instruction = {6'h02, 26'h0000090};
        cycle(); chk("jump_over_br", pc, 32'h240);

        do_jump(26'h14, 1'b1); chk("to_0x50", pc, 32'h50);
        for (int i = 0; i < 3; i++) begin
            idle(); stall = 1'b1; jump_sel = 1'b1; instruction = {6'h02, 26'h100};
            cycle(); chk("stall_hold", pc, 32'h50);
        end
        exception = 1'b1; cycle();
        chk("exc_pc", pc, 32'h8000_0180);
        chk("exc_epc", epc, 32'h50);
        chk("exc_ras", ras_top, 32'h244);

        for (int n = 0; n < 3000; n++) begin
            idle();
            rst_n       = ($urandom_range(0, 199) != 0);
            exception   = ($urandom_range(0, 31) == 0);
            stall       = ($urandom_range(0, 5) == 0);
            jr_sel      = ($urandom_range(0, 5) == 0);
            jump_sel    = ($urandom_range(0, 3) == 0);
            link_sel    = $urandom_range(0, 1);
            branch_sel  = ($urandom_range(0, 3) == 0);
            zero        = $urandom_range(0, 1);
            instruction = $urandom;
            if (ras_q.size() != 0 && $urandom_range(0, 1) == 1)
                reg_target = ras_q[$] | 32'($urandom_range(0, 3));
            else
                reg_target = $urandom;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
